traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Two-road intersection controller that sequences a main-road and a side-road lamp group through timed green, yellow and all-red phases. Main road rests in green. It yields to the side road only after a minimum green time, and only when a side-road vehicle or a pedestrian is waiting. It sits above the single-lamp cyclic sequencer and drives both lamp groups and a pedestrian walk lamp from one clock.

## Interface

Parameters:
- `CNT_W`, default 4: width of the dwell timer.
- `T_MAIN_MIN`, default 8: minimum main-green dwell, in cycles.
- `T_SIDE`, default 6: side-green dwell, in cycles.
- `T_YEL`, default 2: yellow dwell, in cycles, for both roads.
- `T_CLR`, default 1: all-red clearance dwell, in cycles.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `side_car`, input, 1: level; a side-road vehicle is present.
- `ped_req`, input, 1: pedestrian button; sampled every cycle.
- `main_light`, output, 3: main-road lamps, one-hot: red=100, green=010, yellow=001.
- `side_light`, output, 3: side-road lamps, same encoding.
- `walk`, output, 1: pedestrian walk lamp.
- `ped_ack`, output, 1: one-cycle pulse when a latched pedestrian request is served.
- `phase`, output, 3: current state code, for debug and verification.

All durations must be in the range 1..2^CNT_W−1. Out-of-range values are illegal and are not checked.

## Operation

State sequence and codes:
- MAIN_GRN (0) → MAIN_YEL (1) → CLR_A (2) → SIDE_GRN (3) → SIDE_YEL (4) → CLR_B (5) → MAIN_GRN.
- Codes 6 and 7 are illegal. Either code forces MAIN_GRN on the next edge.

Lamps per state:
- MAIN_GRN: main green, side red.
- MAIN_YEL: main yellow, side red.
- CLR_A, CLR_B: both red.
- SIDE_GRN: main red, side green.
- SIDE_YEL: main red, side yellow.

Lamp outputs decode combinationally from the state register. Exactly one bit is set per group at all times.

Dwell timer:
- Loaded with (duration − 1) on the edge that enters a state.
- Decrements each cycle while nonzero, then holds at 0.
- Every timed state lasts exactly its duration in cycles.

Transition rules:
- MAIN_GRN exits only when timer==0 AND (`side_car` OR `ped_pend`). Otherwise it holds indefinitely with the timer at 0.
- All other states exit when timer==0, unconditionally.

Pedestrian latch `ped_pend`:
- Set by `ped_req` in any state except SIDE_GRN and SIDE_YEL. Requests arriving in those two states are ignored.
- Cleared on the edge entering SIDE_GRN.
- On that same edge, `walk_en` is captured from the old `ped_pend`, and `ped_ack` pulses for the first SIDE_GRN cycle if `walk_en` was captured as 1.

`walk` = (state==SIDE_GRN) AND `walk_en`. It is never high while side_light is yellow, or whenever main_light is not red.

## Timing

Reset (`rst_n` low at a rising edge), taking effect on that edge:
- State = MAIN_GRN, timer = T_MAIN_MIN−1.
- `ped_pend`=0, `walk_en`=0.
- Outputs: `main_light`=010, `side_light`=100, `walk`=0, `ped_ack`=0, `phase`=0.
- Reset mid-phase aborts the phase immediately, with no yellow.

Latency:
- Inputs are sampled on an edge; state changes on that same edge.
- Lamps change 0 cycles after the state register, with no extra pipeline stage.

Boundary conditions:
- `side_car` and `ped_req` high together: a single side phase serves both.
- `side_car` dropping during MAIN_YEL or later does not abort the sequence.
- `side_car` held high continuously gives a full 20-cycle period with defaults: 8+2+1+6+2+1.
- A duration of 1 gives a single-cycle state with timer loaded to 0.

## Structure

- Package `traffic_pkg` holds:
  - The state enum with the codes above.
  - The lamp constants RED/GREEN/YELLOW (3-bit one-hot).
  - A function mapping state to the (main, side) lamp pair.
- Sub-module `phase_timer`: CNT_W-bit loadable down-counter.
  - Inputs: `clk`, `rst_n`, `load`, `load_val`.
  - Output: `zero`.
  - Instantiated once.
- The top module holds the FSM, the pedestrian latch and the output decode.

## Test plan

1. Reset, then `side_car`=0 and `ped_req`=0 for 50 cycles → `phase` stays 0, `main_light`=010, `side_light`=100 every cycle.
2. `side_car`=1 from reset → `phase` reads 0×8, 1×2, 2×1, 3×6, 4×2, 5×1, then returns to 0 at cycle 20, repeating with period 20.
3. `ped_req` pulsed 1 cycle at cycle 3 with `side_car`=0 → SIDE_GRN entered at cycle 11; `ped_ack` high at cycle 11 only; `walk` high cycles 11–16; `ped_pend` cleared.
4. `ped_req` pulsed during SIDE_GRN (no `side_car`) → ignored; after CLR_B, main green rests indefinitely and `ped_ack` does not pulse again.
5. `rst_n` low for one edge while in SIDE_GRN → next cycle `phase`=0, `main_light`=010, `side_light`=100, `walk`=0; main green then lasts a full 8 cycles before any exit.
6. Every cycle across a 2000-cycle random run of `side_car`/`ped_req`: each lamp group is one-hot; at least one group is red; `walk` implies `side_light`=010.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lamp encodings and lamp decode for traffic_phase_ctrl
//
// Contents:
//   state_t      - phase state codes (MAIN_GRN=0 .. CLR_B=5; 6 and 7 are illegal)
//   RED/GREEN/YELLOW - 3-bit one-hot lamp encodings
//   lamp_pair_t  - main and side lamp group pair
//   lamps_for()  - maps a phase state to its lamp pair

package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    CLR_A    = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    CLR_B    = 3'd5
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  typedef struct packed {
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
  } lamp_pair_t;

  // Illegal codes show all-red so both groups stay one-hot and conflict-free
  // for the single cycle before the FSM recovers to MAIN_GRN.
  function automatic lamp_pair_t lamps_for(input state_t s);
    lamp_pair_t l;
    case (s)
      MAIN_GRN: l = '{main_lamp: GREEN,  side_lamp: RED};
      MAIN_YEL: l = '{main_lamp: YELLOW, side_lamp: RED};
      SIDE_GRN: l = '{main_lamp: RED,    side_lamp: GREEN};
      SIDE_YEL: l = '{main_lamp: RED,    side_lamp: YELLOW};
      default:  l = '{main_lamp: RED,    side_lamp: RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that times each traffic phase
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset, counter takes RST_VAL
//   load     - load load_val on this edge (wins over counting)
//   load_val - value loaded, duration minus one
//   zero     - counter is at zero

module phase_timer #(
  parameter int unsigned          CNT_W   = 4,
  parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Counts down while nonzero, then parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road intersection phase sequencer with pedestrian walk
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset, returns to main green
//   side_car   - side-road vehicle present (level)
//   ped_req    - pedestrian button, sampled every cycle
//   main_light - main-road lamps, one-hot red/green/yellow = 100/010/001
//   side_light - side-road lamps, same encoding
//   walk       - pedestrian walk lamp
//   ped_ack    - one-cycle pulse when a latched pedestrian request is served
//   phase      - current state code

module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned T_MAIN_MIN = 8,
  parameter int unsigned T_SIDE     = 6,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_CLR      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  state_t           state;
  state_t           state_nxt;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             enter_side;
  logic             ped_pend;
  logic             walk_en;
  logic             ped_ack_q;
  lamp_pair_t       lamps;

  // Timer preload for the state being entered.
  function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
    case (s)
      MAIN_YEL, SIDE_YEL: return CNT_W'(T_YEL - 1);
      CLR_A, CLR_B:       return CNT_W'(T_CLR - 1);
      SIDE_GRN:           return CNT_W'(T_SIDE - 1);
      default:            return CNT_W'(T_MAIN_MIN - 1);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MAIN_GRN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Main green is the rest state: it only yields once the minimum
      // dwell has elapsed and someone is actually waiting.
      MAIN_GRN: if (timer_zero && (side_car || ped_pend)) state_nxt = MAIN_YEL;
      MAIN_YEL: if (timer_zero) state_nxt = CLR_A;
      CLR_A:    if (timer_zero) state_nxt = SIDE_GRN;
      SIDE_GRN: if (timer_zero) state_nxt = SIDE_YEL;
      SIDE_YEL: if (timer_zero) state_nxt = CLR_B;
      CLR_B:    if (timer_zero) state_nxt = MAIN_GRN;
      default:  state_nxt = MAIN_GRN;
    endcase
  end

  // Every state change reloads the timer, including recovery from an
  // illegal code, so each entered state gets its full dwell.
  assign timer_load = (state_nxt != state);
  assign timer_val  = dwell_m1(state_nxt);
  assign enter_side = (state_nxt == SIDE_GRN) && (state != SIDE_GRN);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_MAIN_MIN - 1))
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Requests during side green/yellow are dropped: that side phase is
  // already committed and the crossing cannot be offered mid-phase.
  // Clearing on side-green entry takes priority over a same-edge request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pend  <= 1'b0;
      walk_en   <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      ped_ack_q <= enter_side && ped_pend;
      if (enter_side) begin
        walk_en  <= ped_pend;
        ped_pend <= 1'b0;
      end else if (ped_req && (state != SIDE_GRN) && (state != SIDE_YEL)) begin
        ped_pend <= 1'b1;
      end
    end
  end

  assign lamps      = lamps_for(state);
  assign main_light = lamps.main_lamp;
  assign side_light = lamps.side_lamp;
  assign walk       = (state == SIDE_GRN) && walk_en;
  assign ped_ack    = ped_ack_q;
  assign phase      = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for traffic_phase_ctrl

module tb_traffic_phase_ctrl;

  localparam int T_MAIN = 8;
  localparam int T_SD   = 6;
  localparam int T_Y    = 2;
  localparam int T_C    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  traffic_phase_ctrl #(
    .CNT_W(4), .T_MAIN_MIN(T_MAIN), .T_SIDE(T_SD), .T_YEL(T_Y), .T_CLR(T_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .side_car(side_car), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    logic       ak;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int m_state = 0;
  int m_left = T_MAIN;
  bit m_pend = 0;
  bit m_walk_en = 0;
  bit m_ack = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dwell(input int s);
    case (s)
      1, 4:    return T_Y;
      2, 5:    return T_C;
      3:       return T_SD;
      default: return T_MAIN;
    endcase
  endfunction

  function automatic logic [5:0] lamp_ref(input int s);
    case (s)
      0:       return {3'b010, 3'b100};
      1:       return {3'b001, 3'b100};
      3:       return {3'b100, 3'b010};
      4:       return {3'b100, 3'b001};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Expected phase when side_car is held high from reset (period 20).
  function automatic int sc_phase(input int c);
    int r;
    r = c % 20;
    if (r < 8)  return 0;
    if (r < 10) return 1;
    if (r < 11) return 2;
    if (r < 17) return 3;
    if (r < 19) return 4;
    return 5;
  endfunction

  // Model: m_left counts cycles remaining in the current state, including this one.
  task automatic model_step(input bit sc, input bit pr, input bit rn);
    int ns;
    bit pend_n;
    bit ack_n;
    bit go;
    if (!rn) begin
      m_state = 0; m_left = T_MAIN; m_pend = 0; m_walk_en = 0; m_ack = 0;
    end else begin
      ns = m_state;
      pend_n = m_pend;
      ack_n = 0;
      if (pr && m_state != 3 && m_state != 4) pend_n = 1;
      go = (m_left == 1) && (m_state != 0 || sc || m_pend);
      if (go) begin
        ns = (m_state + 1) % 6;
        m_left = dwell(ns);
        if (ns == 3) begin
          m_walk_en = m_pend;
          ack_n = m_pend;
          pend_n = 0;
        end
      end else if (m_left > 1) begin
        m_left--;
      end
      m_state = ns;
      m_pend = pend_n;
      m_ack = ack_n;
    end
  endtask

  task automatic cycle(input bit sc, input bit pr, input bit rn);
    exp_t e;
    logic [5:0] lp;
    side_car = sc;
    ped_req = pr;
    rst_n = rn;
    model_step(sc, pr, rn);
    lp = lamp_ref(m_state);
    e.ph = 3'(m_state);
    e.ml = lp[5:3];
    e.sl = lp[2:0];
    e.wk = (m_state == 3) && m_walk_en;
    e.ak = m_ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("phase", 32'(phase), 32'(e.ph));
    check("main_light", 32'(main_light), 32'(e.ml));
    check("side_light", 32'(side_light), 32'(e.sl));
    check("walk", 32'(walk), 32'(e.wk));
    check("ped_ack", 32'(ped_ack), 32'(e.ak));
    check("main_onehot", 32'($onehot(main_light)), 32'd1);
    check("side_onehot", 32'($onehot(side_light)), 32'd1);
    check("one_red", 32'((main_light == 3'b100) || (side_light == 3'b100)), 32'd1);
    check("walk_side_grn", 32'(!walk || (side_light == 3'b010)), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit found;

    // Idle rest in main green
    cycle(0, 0, 0);
    check("t1_reset_phase", 32'(phase), 32'd0);
    repeat (50) cycle(0, 0, 1);

    // Continuous side_car: 20-cycle period
    cycle(1, 0, 0);
    for (int i = 0; i < 45; i++) begin
      cycle(1, 0, 1);
      check("t2_period", 32'(phase), 32'(sc_phase(i + 1)));
    end

    // Single pedestrian pulse at cycle 3
    cycle(0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      cycle(0, i == 3, 1);
      check("t3_side_grn", 32'(phase == 3'd3), 32'((i + 1 >= 11) && (i + 1 <= 16)));
      check("t3_ack", 32'(ped_ack), 32'(i + 1 == 11));
      check("t3_walk", 32'(walk), 32'((i + 1 >= 11) && (i + 1 <= 16)));
    end
    check("t3_rest", 32'(phase), 32'd0);

    // Pedestrian request during side green is ignored
    cycle(0, 0, 0);
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(i < 8, i == 13, 1);
      acks += int'(ped_ack);
    end
    check("t4_ack_count", 32'(acks), 32'd0);
    check("t4_rest", 32'(phase), 32'd0);

    // Reset during side green
    cycle(0, 0, 0);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (!found) begin
        cycle(1, 0, 1);
        if (phase == 3'd3) found = 1;
      end
    end
    check("t5_reach_side", 32'(found), 32'd1);
    cycle(1, 0, 0);
    check("t5_phase", 32'(phase), 32'd0);
    check("t5_main", 32'(main_light), 32'b010);
    check("t5_side", 32'(side_light), 32'b100);
    check("t5_walk", 32'(walk), 32'd0);
    for (int j = 0; j < 10; j++) begin
      cycle(1, 0, 1);
      check("t5_main_hold", 32'(phase), 32'(sc_phase(j + 1)));
    end

    // Random run
    cycle(0, 0, 0);
    repeat (2000) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
